// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator CPU: opcodes, sequencer phases and widths.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned PHASE_W  = 3;

  localparam logic [OPCODE_W-1:0] HLT = 3'd0;
  localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
  localparam logic [OPCODE_W-1:0] ADD = 3'd2;
  localparam logic [OPCODE_W-1:0] AND = 3'd3;
  localparam logic [OPCODE_W-1:0] XOR = 3'd4;
  localparam logic [OPCODE_W-1:0] LDA = 3'd5;
  localparam logic [OPCODE_W-1:0] STO = 3'd6;
  localparam logic [OPCODE_W-1:0] JMP = 3'd7;

  // ALU-side names for the same encodings
  localparam logic [OPCODE_W-1:0] PASS0 = HLT;
  localparam logic [OPCODE_W-1:0] PASS1 = SKZ;
  localparam logic [OPCODE_W-1:0] PASS2 = ADD;
  localparam logic [OPCODE_W-1:0] PASS3 = AND;
  localparam logic [OPCODE_W-1:0] PASS4 = XOR;
  localparam logic [OPCODE_W-1:0] PASS5 = LDA;
  localparam logic [OPCODE_W-1:0] PASS6 = STO;
  localparam logic [OPCODE_W-1:0] PASS7 = JMP;

  localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
  localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
  localparam logic [PHASE_W-1:0] IDLE       = 3'd3;
  localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
  localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
  localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
  localparam logic [PHASE_W-1:0] STORE      = 3'd7;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational phase/opcode/zero -> datapath strobe decoder (halt_q overrides live in cpu_ctrl).
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [PHASE_W-1:0]  phase,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                halt,
  output logic                ld_pc,
  output logic                data_e,
  output logic                ld_ac,
  output logic                wr
);

  logic aluop;

  assign aluop = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    unique case (phase)
      INST_ADDR: sel = 1'b1;
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = (opcode != HLT);
        halt   = (opcode == HLT);
      end
      OP_FETCH: rd = aluop;
      // zero only matters here, for the SKZ skip
      ALU_OP: begin
        rd     = aluop;
        inc_pc = (opcode == SKZ) && zero;
        ld_pc  = (opcode == JMP);
        data_e = (opcode == STO);
      end
      STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        inc_pc = (opcode == JMP);
        ld_pc  = (opcode == JMP);
        wr     = (opcode == STO);
        data_e = (opcode == STO);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction sequencer: 8-phase counter with sticky halt; strobes decoded combinationally.
// Optional CTRL_RESUME_EN adds a resume input that releases halt and skips the HLT word.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
`ifdef CTRL_RESUME_EN
  input  logic                resume,
`endif
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                halt,
  output logic                ld_pc,
  output logic                data_e,
  output logic                ld_ac,
  output logic                wr,
  output logic [PHASE_W-1:0]  phase
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               halt_q, halt_d;
  logic               resume_hit;
  logic d_sel, d_rd, d_ld_ir, d_inc_pc, d_halt, d_ld_pc, d_data_e, d_ld_ac, d_wr;

`ifdef CTRL_RESUME_EN
  assign resume_hit = halt_q && resume;
`else
  assign resume_hit = 1'b0;
`endif

  cpu_ctrl_decode u_decode (
    .phase  (phase_q),
    .opcode (opcode),
    .zero   (zero),
    .sel    (d_sel),
    .rd     (d_rd),
    .ld_ir  (d_ld_ir),
    .inc_pc (d_inc_pc),
    .halt   (d_halt),
    .ld_pc  (d_ld_pc),
    .data_e (d_data_e),
    .ld_ac  (d_ld_ac),
    .wr     (d_wr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= INST_ADDR;
      halt_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      halt_q  <= halt_d;
    end
  end

  // Next phase and halt overrides on the decoded strobes
  always_comb begin
    phase_d = phase_q + PHASE_W'(1);
    halt_d  = halt_q;
    sel     = d_sel;
    rd      = d_rd;
    ld_ir   = d_ld_ir;
    inc_pc  = d_inc_pc;
    halt    = d_halt;
    ld_pc   = d_ld_pc;
    data_e  = d_data_e;
    ld_ac   = d_ld_ac;
    wr      = d_wr;
    if (halt_q) begin
      phase_d = phase_q;
      sel     = 1'b0;
      rd      = 1'b0;
      ld_ir   = 1'b0;
      inc_pc  = 1'b0;
      halt    = 1'b1;
      ld_pc   = 1'b0;
      data_e  = 1'b0;
      ld_ac   = 1'b0;
      wr      = 1'b0;
      if (resume_hit) begin
        halt    = 1'b0;
        inc_pc  = 1'b1;
        halt_d  = 1'b0;
        phase_d = OP_FETCH;
      end
    end else if ((phase_q == OP_ADDR) && (opcode == HLT)) begin
      phase_d = phase_q;
      halt_d  = 1'b1;
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: driver queues per-cycle expectations, negedge monitor checks them.
module tb_cpu_ctrl;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       resume = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;

  cpu_ctrl dut (
    .clk    (clk),
    .rst    (rst),
`ifdef CTRL_RESUME_EN
    .resume (resume),
`endif
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .halt   (halt),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  // strobe order: {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}
  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_P0   = 9'b100000000;
  localparam logic [8:0] S_P1   = 9'b110000000;
  localparam logic [8:0] S_P23  = 9'b111000000;
  localparam logic [8:0] S_INC  = 9'b000100000;
  localparam logic [8:0] S_HALT = 9'b000010000;
  localparam logic [8:0] S_RD   = 9'b010000000;
  localparam logic [8:0] S_RDAC = 9'b010000010;
  localparam logic [8:0] S_DE   = 9'b000000100;
  localparam logic [8:0] S_DEWR = 9'b000000101;
  localparam logic [8:0] S_LPC  = 9'b000001000;
  localparam logic [8:0] S_JMP7 = 9'b000101000;

  typedef struct {
    logic [2:0] ph;
    logic [8:0] st;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  logic [8:0] act_st;
  assign act_st = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({phase, act_st} !== {e.ph, e.st}) begin
        n_fail++;
        $display("FAIL %s: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                 e.name, phase, act_st, e.ph, e.st);
      end
    end
  end

  // Drive one cycle's inputs and optionally queue that cycle's expected outputs
  task automatic cyc(input logic r, input logic [2:0] op, input logic z, input logic res,
                     input logic chk, input logic [2:0] eph, input logic [8:0] est,
                     input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    opcode = op;
    zero   = z;
    resume = res;
    if (chk) begin
      e.ph   = eph;
      e.st   = est;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic fetch(input logic [2:0] op, input string name);
    cyc(1'b0, op, 1'b0, 1'b0, 1'b1, 3'd0, S_P0,  {name, "_p0"});
    cyc(1'b0, op, 1'b0, 1'b0, 1'b1, 3'd1, S_P1,  {name, "_p1"});
    cyc(1'b0, op, 1'b0, 1'b0, 1'b1, 3'd2, S_P23, {name, "_p2"});
    cyc(1'b0, op, 1'b0, 1'b0, 1'b1, 3'd3, S_P23, {name, "_p3"});
  endtask

  task automatic run8(input logic [2:0] op, input logic z, input logic [8:0] e4,
                      input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7,
                      input string name);
    fetch(op, name);
    cyc(1'b0, op, z, 1'b0, 1'b1, 3'd4, e4, {name, "_p4"});
    cyc(1'b0, op, z, 1'b0, 1'b1, 3'd5, e5, {name, "_p5"});
    cyc(1'b0, op, z, 1'b0, 1'b1, 3'd6, e6, {name, "_p6"});
    cyc(1'b0, op, z, 1'b0, 1'b1, 3'd7, e7, {name, "_p7"});
  endtask

  task automatic do_reset();
    cyc(1'b1, ADD, 1'b0, 1'b0, 1'b0, 3'd0, S_NONE, "rst");
    cyc(1'b1, ADD, 1'b0, 1'b0, 1'b0, 3'd0, S_NONE, "rst");
  endtask

  initial begin
    do_reset();

    run8(ADD, 1'b0, S_INC, S_RD, S_RD, S_RDAC, "add");
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b1, 3'd0, S_P0, "add_wrap");
    cyc(1'b0, AND, 1'b0, 1'b0, 1'b1, 3'd1, S_P1, "and_p1");
    cyc(1'b0, AND, 1'b0, 1'b0, 1'b1, 3'd2, S_P23, "and_p2");
    cyc(1'b0, AND, 1'b0, 1'b0, 1'b1, 3'd3, S_P23, "and_p3");
    cyc(1'b0, AND, 1'b0, 1'b0, 1'b1, 3'd4, S_INC, "and_p4");
    cyc(1'b0, AND, 1'b0, 1'b0, 1'b1, 3'd5, S_RD, "and_p5");
    cyc(1'b0, AND, 1'b1, 1'b0, 1'b1, 3'd6, S_RD, "and_p6_zero_ignored");
    cyc(1'b0, AND, 1'b0, 1'b0, 1'b1, 3'd7, S_RDAC, "and_p7");

    run8(SKZ, 1'b1, S_INC, S_NONE, S_INC, S_NONE, "skz_z1");
    run8(SKZ, 1'b0, S_INC, S_NONE, S_NONE, S_NONE, "skz_z0");
    run8(STO, 1'b0, S_INC, S_NONE, S_DE, S_DEWR, "sto");
    run8(JMP, 1'b0, S_INC, S_NONE, S_LPC, S_JMP7, "jmp");
    run8(LDA, 1'b0, S_INC, S_RD, S_RD, S_RDAC, "lda");

    // reset mid-instruction wins over a pending STO write
    fetch(STO, "sto_rst");
    cyc(1'b0, STO, 1'b0, 1'b0, 1'b1, 3'd4, S_INC, "sto_rst_p4");
    cyc(1'b0, STO, 1'b0, 1'b0, 1'b1, 3'd5, S_NONE, "sto_rst_p5");
    cyc(1'b1, STO, 1'b0, 1'b0, 1'b1, 3'd6, S_DE, "sto_rst_p6");
    cyc(1'b0, STO, 1'b0, 1'b0, 1'b1, 3'd0, S_P0, "sto_rst_after");
    cyc(1'b0, STO, 1'b0, 1'b0, 1'b1, 3'd1, S_P1, "sto_rst_p1");
    do_reset();

    // halt is sticky; opcode changes are ignored
    fetch(HLT, "hlt");
    cyc(1'b0, HLT, 1'b0, 1'b1, 1'b1, 3'd4, S_HALT, "hlt_decode");
    for (int i = 0; i < 20; i++)
      cyc(1'b0, (i >= 10) ? ADD : HLT, i[0], 1'b0, 1'b1, 3'd4, S_HALT, "hlt_hold");
    cyc(1'b1, ADD, 1'b0, 1'b0, 1'b1, 3'd4, S_HALT, "hlt_rst_cycle");
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b1, 3'd0, S_P0, "hlt_after_rst");
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b1, 3'd1, S_P1, "hlt_after_rst_p1");
    do_reset();

`ifdef CTRL_RESUME_EN
    // resume while running is ignored
    fetch(ADD, "res_run");
    cyc(1'b0, ADD, 1'b0, 1'b1, 1'b1, 3'd4, S_INC, "res_run_p4");
    cyc(1'b0, ADD, 1'b0, 1'b1, 1'b1, 3'd5, S_RD, "res_run_p5");
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b1, 3'd6, S_RD, "res_run_p6");
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b1, 3'd7, S_RDAC, "res_run_p7");
    // halt then resume skips the HLT word and completes as a no-op
    fetch(HLT, "res");
    cyc(1'b0, HLT, 1'b0, 1'b1, 1'b1, 3'd4, S_HALT, "res_first_decode");
    cyc(1'b0, HLT, 1'b0, 1'b0, 1'b1, 3'd4, S_HALT, "res_halted");
    cyc(1'b0, HLT, 1'b0, 1'b1, 1'b1, 3'd4, S_INC, "res_pulse");
    cyc(1'b0, HLT, 1'b0, 1'b0, 1'b1, 3'd5, S_NONE, "res_p5");
    cyc(1'b0, HLT, 1'b1, 1'b0, 1'b1, 3'd6, S_NONE, "res_p6");
    cyc(1'b0, HLT, 1'b0, 1'b0, 1'b1, 3'd7, S_NONE, "res_p7");
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b1, 3'd0, S_P0, "res_p0");
    do_reset();
    // reset beats resume
    fetch(HLT, "res_rst");
    cyc(1'b0, HLT, 1'b0, 1'b0, 1'b1, 3'd4, S_HALT, "res_rst_halt");
    cyc(1'b1, HLT, 1'b0, 1'b1, 1'b1, 3'd4, S_INC, "res_rst_both");
    cyc(1'b0, HLT, 1'b0, 1'b0, 1'b1, 3'd0, S_P0, "res_rst_after");
`endif

    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0, 3'd0, S_NONE, "drain");
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0, 3'd0, S_NONE, "drain");
    @(posedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
